// File: rtl/frac_clk_pkg.sv
// Shared types and default widths for the fractional clock generator.
package frac_clk_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam int ACC_W_DEF = 32;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/frac_clk_acc.sv
// Phase accumulator: adds the increment every enabled cycle and reports the
// carry out of the top bit, which marks one output tick.
module frac_clk_acc
   import frac_clk_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [ACC_W-1:0] inc,
   output logic [ACC_W-1:0] acc,
   output logic             carry
);

   logic [ACC_W-1:0] acc_d, acc_q;
   logic [ACC_W:0]   sum;

   // Sum at ACC_W+1 bits; the carry is valid every cycle, the caller decides
   // whether it counts.
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, inc};
      carry = sum[ACC_W];
      acc_d = acc_q;
      if (clr)
         acc_d = '0;
      else if (en)
         acc_d = sum[ACC_W-1:0];
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/frac_clk_gen.sv
// Fractional clock generator: config register, start/stop FSM, tick pulse,
// divided clock and tick counter around a phase accumulator.
module frac_clk_gen
   import frac_clk_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   input  logic [ACC_W-1:0] cfg_inc,
   output logic             cfg_ready,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             tick,
   output logic             clk_out,
   output logic [CNT_W-1:0] tick_count
);

   state_t           state_d, state_q;
   logic [ACC_W-1:0] inc_d, inc_q;
   logic             clk_out_d, clk_out_q;
   logic             tick_d, tick_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             acc_clr, acc_en, carry;
   // Phase value itself is not needed here; only its carry drives outputs.
   logic [ACC_W-1:0] acc_unused;

   frac_clk_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .inc   (inc_q),
      .acc   (acc_unused),
      .carry (carry)
   );

   // Next-state and datapath control. Outside IDLE every cycle accumulates;
   // stop sequencing only ever leaves on a cycle where clk_out ends low.
   always_comb begin
      state_d   = state_q;
      inc_d     = inc_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      cnt_d     = cnt_q;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;

      case (state_q)
         IDLE: begin
            // start looks at the increment already held, not one arriving now
            if (start && (inc_q != '0)) begin
               state_d   = RUN;
               acc_clr   = 1'b1;
               cnt_d     = '0;
               clk_out_d = 1'b0;
            end
            if (cfg_valid)
               inc_d = cfg_inc;
         end
         RUN: begin
            if (stop)
               state_d = (!clk_out_q && !carry) ? IDLE : STOPPING;
         end
         STOPPING: begin
            // only a 1->0 transition of clk_out finishes the stop
            if (carry && clk_out_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
         acc_en    = 1'b1;
         tick_d    = carry;
         clk_out_d = clk_out_q ^ carry;
         cnt_d     = cnt_q + CNT_W'(carry);
      end
   end

   // State, config and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         inc_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         inc_q     <= inc_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         cnt_q     <= cnt_d;
      end
   end

   assign cfg_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign tick       = tick_q;
   assign clk_out    = clk_out_q;
   assign tick_count = cnt_q;

endmodule
